// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// Module  : mem_bus_arb_pkg
// Purpose : Shared types and default parameters for the memory bus arbiter.
//           owner_e identifies which master owns an outstanding transaction.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_bus_arb_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int unsigned DEF_MAX_OUTSTANDING = 2;
  localparam int unsigned DEF_STARVE_LIMIT    = 4;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_owner_fifo.sv
// ============================================================================
// Module  : arb_owner_fifo
// Purpose : Parameterised-depth 1-bit FIFO recording the owner of every
//           accepted transaction, oldest at the head.
// Ports   : clk, rst (async, active-high)
//           push_i/din_i  - enqueue din_i (ignored when full)
//           pop_i         - dequeue head (ignored when empty)
//           full_o, empty_o, head_o
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module arb_owner_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_w, pop_w;

  // Pointers wrap explicitly so non power-of-two depths would also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == C_DEPTH);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign push_w  = push_i & ~full_o;
  assign pop_w   = pop_i & ~empty_o;

  always_comb begin
    wptr_d = push_w ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop_w ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    case ({push_w, pop_w})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_w) mem_q[wptr_q] <= din_i;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module  : mem_bus_arbiter
// Purpose : Shares one req/gnt/rvalid memory port between instruction fetch
//           (master 0, read-only) and load/store (master 1). Tracks the owner
//           of each outstanding transaction and routes in-order responses
//           back to it. Data has priority; an instruction request denied
//           STARVE_LIMIT consecutive cycles is forced through.
//           Build option MEM_BUS_ARB_ROUND_ROBIN_EN replaces the starvation
//           escape with round-robin selection on contention.
// Ports   : clk, rst (async, active-high)
//           m0_*  - instruction master (req/addr in; gnt/rvalid/rdata/err out)
//           m1_*  - data master (req/we/be/addr/wdata in; gnt/rvalid/rdata/err)
//           s_*   - slave port (req/we/be/addr/wdata out; gnt/rvalid/rdata/err)
//           unexp_rsp_o - pulse when a response arrives with nothing pending
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  input  logic        s_err_i,
  output logic        unexp_rsp_o
);

  owner_e sel_w;
  logic   any_req_w;
  logic   fifo_full_w, fifo_empty_w, fifo_head_w;
  logic   pop_w, push_w;

  assign any_req_w = m0_req_i | m1_req_i;

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
  // last_grant_q resets to data, so the first contention goes to fetch.
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (m0_req_i && m1_req_i) sel_w = last_grant_q ? OWNER_INSTR : OWNER_DATA;
    else                      sel_w = m1_req_i ? OWNER_DATA : OWNER_INSTR;
    last_grant_d = push_w ? (sel_w == OWNER_DATA) : last_grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`else
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    sel_w = (m1_req_i && (!m0_req_i || (starve_cnt_q < C_STARVE_MAX)))
            ? OWNER_DATA : OWNER_INSTR;
    // Counts consecutive denied fetch cycles; any gap or grant restarts it.
    starve_cnt_d = '0;
    if (m0_req_i && !m0_gnt_o)
      starve_cnt_d = (starve_cnt_q == C_STARVE_MAX) ? starve_cnt_q
                                                     : starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`endif

  // A full owner FIFO blocks new requests even if a response pops it this
  // cycle; there is deliberately no bypass path. Outputs are forced to 0
  // while rst is held.
  assign s_req_o = any_req_w & ~fifo_full_w & ~rst;

  always_comb begin
    s_we_o    = 1'b0;
    s_be_o    = 4'h0;
    s_addr_o  = 32'h0;
    s_wdata_o = 32'h0;
    if (any_req_w && !rst) begin
      if (sel_w == OWNER_DATA) begin
        s_we_o    = m1_we_i;
        s_be_o    = m1_be_i;
        s_addr_o  = m1_addr_i;
        s_wdata_o = m1_wdata_i;
      end else begin
        s_be_o    = 4'hF;
        s_addr_o  = m0_addr_i;
      end
    end
  end

  assign m0_gnt_o = s_gnt_i & s_req_o & (sel_w == OWNER_INSTR);
  assign m1_gnt_o = s_gnt_i & s_req_o & (sel_w == OWNER_DATA);
  assign push_w   = m0_gnt_o | m1_gnt_o;

  assign pop_w       = s_rvalid_i & ~fifo_empty_w & ~rst;
  assign unexp_rsp_o = s_rvalid_i & fifo_empty_w & ~rst;

  assign m0_rvalid_o = pop_w & (fifo_head_w == OWNER_INSTR);
  assign m1_rvalid_o = pop_w & (fifo_head_w == OWNER_DATA);
  assign m0_err_o    = m0_rvalid_o & s_err_i;
  assign m1_err_o    = m1_rvalid_o & s_err_i;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_w),
    .pop_i   (pop_w),
    .din_i   (sel_w == OWNER_DATA),
    .full_o  (fifo_full_w),
    .empty_o (fifo_empty_w),
    .head_o  (fifo_head_w)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Purpose : Self-checking bench for mem_bus_arbiter. A queue-based reference
//           model predicts every output each cycle from the applied inputs.
//           Honours MEM_BUS_ARB_ROUND_ROBIN_EN in the model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  localparam int MAX_OUT = 2;
  localparam int LIMIT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_we, s_gnt, s_rvalid, s_err, unexp;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata, s_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .MAX_OUTSTANDING (MAX_OUT),
    .STARVE_LIMIT    (LIMIT)
  ) dut (
    .clk (clk), .rst (rst),
    .m0_req_i (m0_req), .m0_addr_i (m0_addr), .m0_gnt_o (m0_gnt),
    .m0_rvalid_o (m0_rvalid), .m0_rdata_o (m0_rdata), .m0_err_o (m0_err),
    .m1_req_i (m1_req), .m1_we_i (m1_we), .m1_be_i (m1_be),
    .m1_addr_i (m1_addr), .m1_wdata_i (m1_wdata), .m1_gnt_o (m1_gnt),
    .m1_rvalid_o (m1_rvalid), .m1_rdata_o (m1_rdata), .m1_err_o (m1_err),
    .s_req_o (s_req), .s_we_o (s_we), .s_be_o (s_be), .s_addr_o (s_addr),
    .s_wdata_o (s_wdata), .s_gnt_i (s_gnt), .s_rvalid_i (s_rvalid),
    .s_rdata_i (s_rdata), .s_err_i (s_err), .unexp_rsp_o (unexp)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: owners of outstanding transactions, oldest first.
  bit owner_q[$];
  int starve   = 0;
  bit last_gnt = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One bus cycle: apply inputs (called just after a falling edge), compare
  // all outputs to the model, then advance the model across the rising edge.
  task automatic step(input bit a0, input bit a1, input bit we, input logic [3:0] be,
                      input logic [31:0] ad0, input logic [31:0] ad1,
                      input logic [31:0] wd, input bit gnt, input bit rv,
                      input bit er, input logic [31:0] rd);
    bit any, sel, sreq, g0, g1, pop, own;
    m0_req = a0; m1_req = a1; m1_we = we; m1_be = be;
    m0_addr = ad0; m1_addr = ad1; m1_wdata = wd;
    s_gnt = gnt; s_rvalid = rv; s_err = er; s_rdata = rd;
    #1;
    any = a0 | a1;
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    sel = (a0 && a1) ? !last_gnt : a1;
`else
    sel = a1 && (!a0 || starve < LIMIT);
`endif
    sreq = any && (owner_q.size() < MAX_OUT);
    g0   = gnt && sreq && !sel;
    g1   = gnt && sreq && sel;
    pop  = rv && (owner_q.size() > 0);
    own  = pop ? owner_q[0] : 1'b0;
    chk("s_req",    s_req,   32'(sreq));
    chk("s_addr",   s_addr,  !any ? 32'h0 : (sel ? ad1 : ad0));
    chk("s_we",     s_we,    32'(any && sel && we));
    chk("s_be",     s_be,    !any ? 32'h0 : (sel ? 32'(be) : 32'hF));
    chk("s_wdata",  s_wdata, (any && sel) ? wd : 32'h0);
    chk("m0_gnt",   m0_gnt,  32'(g0));
    chk("m1_gnt",   m1_gnt,  32'(g1));
    chk("m0_rvalid", m0_rvalid, 32'(pop && !own));
    chk("m1_rvalid", m1_rvalid, 32'(pop && own));
    chk("m0_err",   m0_err,  32'(pop && !own && er));
    chk("m1_err",   m1_err,  32'(pop && own && er));
    chk("unexp",    unexp,   32'(rv && owner_q.size() == 0));
    chk("m0_rdata", m0_rdata, rd);
    chk("m1_rdata", m1_rdata, rd);
    @(posedge clk);
    if (pop) void'(owner_q.pop_front());
    if (g0 || g1) owner_q.push_back(sel);
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
    if (g0 || g1) last_gnt = sel;
`else
    if (a0 && !g0) starve = (starve >= LIMIT) ? LIMIT : starve + 1;
    else           starve = 0;
`endif
    @(negedge clk);
  endtask

  // Reset with busy inputs: everything but the rdata pass-through must be 0.
  task automatic do_reset();
    logic [31:0] rd;
    rd = $urandom;
    rst = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'h5;
    m0_addr = 32'h10; m1_addr = 32'h20; m1_wdata = 32'h30;
    s_gnt = 1'b1; s_rvalid = 1'b1; s_err = 1'b1; s_rdata = rd;
    #1;
    chk("rst_s_req", s_req, 32'h0);
    chk("rst_s_fields", {s_we, s_be, s_addr[26:0]} | s_wdata, 32'h0);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 32'h0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid, m0_err, m1_err, unexp}, 32'h0);
    chk("rst_rdata", m0_rdata & m1_rdata, rd);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    owner_q.delete();
    starve   = 0;
    last_gnt = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Continuous contention with a slave that accepts and responds every cycle.
    for (int i = 0; i < 15; i++)
      step(1, 1, 0, 4'hF, 32'h100 + 32'(i * 4), 32'h200, 0, 1, 1, 0, $urandom);

    // In-order routing: fetch then data, responses come back to their owners.
    do_reset();
    step(1, 0, 0, 4'h0, 32'h100, 32'h0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 4'hF, 32'h0, 32'h200, 0, 1, 0, 0, 0);
    step(0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 32'hAAAA0000);
    step(0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 32'hBBBB0000);

    // Full FIFO blocks requests, including on the cycle that pops.
    step(1, 1, 1, 4'h3, 32'h40, 32'h44, 32'hDEAD, 1, 0, 0, 0);
    step(1, 1, 1, 4'h3, 32'h40, 32'h44, 32'hDEAD, 1, 0, 0, 0);
    step(1, 1, 1, 4'h3, 32'h40, 32'h44, 32'hDEAD, 1, 0, 0, 0);
    step(1, 1, 1, 4'h3, 32'h40, 32'h44, 32'hDEAD, 1, 1, 0, 32'h1);
    step(1, 1, 1, 4'h3, 32'h40, 32'h44, 32'hDEAD, 1, 0, 0, 0);

    // Simultaneous push and pop with alternating owners; pointers wrap.
    do_reset();
    step(1, 0, 0, 4'h0, 32'h0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step(i[0], !i[0], 1, 4'hC, 32'(i), 32'(i + 100), 32'(i), 1, 1, 0, 32'(i));

    // Unexpected response, then an erroring data response.
    do_reset();
    step(0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 32'h5);
    step(0, 1, 0, 4'hF, 0, 32'h300, 0, 1, 0, 0, 0);
    step(0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 1, 32'h6);

    // Reset with two outstanding; a later stale response is unexpected.
    step(1, 1, 0, 4'hF, 32'h8, 32'h9, 0, 1, 0, 0, 0);
    step(1, 1, 0, 4'hF, 32'h8, 32'h9, 0, 1, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 32'h7);

    // Randomised traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 4'($urandom), $urandom & 32'hFFFF_FFFC,
           $urandom, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory port between the instruction fetch unit (master 0, read-only) and the load/store unit (master 1, read/write).
- Uses the core's req/gnt/rvalid bus protocol on all three sides. Grant is a single-cycle handshake; the response arrives on a later cycle, in order.
- Tracks which master owns each outstanding transaction, routes responses back to that owner, and bounds starvation of instruction fetch behind data traffic.

Parameters:
- MAX_OUTSTANDING, 2: depth of the owner FIFO (outstanding accepted transactions); power of two, >=1.
- STARVE_LIMIT, 4: consecutive denied cycles of a requesting master 0 before it is forced priority; >=1.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- m0_req_i  input  1  instruction request
- m0_addr_i  input  32  instruction address (word aligned)
- m0_gnt_o  output  1  instruction grant
- m0_rvalid_o  output  1  instruction response valid
- m0_rdata_o  output  32  instruction response data
- m0_err_o  output  1  instruction response error
- m1_req_i  input  1  data request
- m1_we_i  input  1  data write enable
- m1_be_i  input  4  data byte enables
- m1_addr_i  input  32  data address
- m1_wdata_i  input  32  data write data
- m1_gnt_o  output  1  data grant
- m1_rvalid_o  output  1  data response valid
- m1_rdata_o  output  32  data response data
- m1_err_o  output  1  data response error
- s_req_o  output  1  slave request
- s_we_o  output  1  slave write enable
- s_be_o  output  4  slave byte enables
- s_addr_o  output  32  slave address
- s_wdata_o  output  32  slave write data
- s_gnt_i  input  1  slave grant
- s_rvalid_i  input  1  slave response valid
- s_rdata_i  input  32  slave response data
- s_err_i  input  1  slave response error
- unexp_rsp_o  output  1  one-cycle pulse: s_rvalid_i arrived with no outstanding transaction

Behaviour:
- Reset (rst=1, asynchronous): FIFO empty, count 0, starve counter 0. All outputs 0, except m*_rdata_o, which passes through s_rdata_i.
- Selection is combinational in the same cycle. sel = 1 (data) if m1_req_i and (not m0_req_i or starve_cnt < STARVE_LIMIT); otherwise sel = 0 when m0_req_i.
- s_req_o = (m0_req_i | m1_req_i) & ~fifo_full.
  - Full blocks new requests even when a pop happens in the same cycle; no bypass.
- Mux fields to the slave from the selected master.
  - Master 0 drives we=0, be=4'hF, wdata=0.
  - With no request, the slave fields are 0.
- mX_gnt_o = s_gnt_i & s_req_o & (sel==X).
- Push on the granted cycle: owner id = sel.
- Pop on s_rvalid_i when the FIFO is not empty. The head owner gets mX_rvalid_o=1 and mX_err_o=s_err_i in the same cycle (zero added latency).
- Push and pop in the same cycle: count unchanged, pointers both advance, wrapping modulo MAX_OUTSTANDING.
- s_rvalid_i with the FIFO empty: no master rvalid, unexp_rsp_o=1 for that cycle, state unchanged.
- starve_cnt, registered:
  - Increments, saturating at STARVE_LIMIT, when m0_req_i=1 and m0 was not granted.
  - Clears when m0 is granted or m0_req_i=0.
- Requests may drop before grant; no request lock.
- rst asserted mid-transaction: outstanding tracking is discarded. Responses arriving after release with the FIFO empty raise unexp_rsp_o.

Optional Feature:
- Macro: MEM_BUS_ARB_ROUND_ROBIN_EN.
- Defined: the starvation counter is removed and selection becomes round-robin.
  - A registered last_grant bit (reset 1) is kept.
  - On contention, the master that is not last_grant wins.
  - last_grant updates on every grant.
- Undefined: data priority with the STARVE_LIMIT escape described under Behaviour.

Decomposition:
- Package mem_bus_arb_pkg holds:
  - typedef owner_e (OWNER_INSTR=1'b0, OWNER_DATA=1'b1)
  - localparam defaults for MAX_OUTSTANDING and STARVE_LIMIT
- Sub-module arb_owner_fifo: parameterised-depth 1-bit FIFO with push/pop/full/empty/head. It is used once for owner tracking.

Test Plan:
- Both masters request continuously, slave gnt=1 every cycle, STARVE_LIMIT=4 -> grants follow m1,m1,m1,m1,m0 repeating; m0 is never denied more than 4 consecutive cycles.
- m0 addr 0x100 granted, then m1 read at 0x200 granted; slave returns rvalid with 0xAAAA0000 then 0xBBBB0000 -> m0_rvalid_o carries 0xAAAA0000, then m1_rvalid_o carries 0xBBBB0000; no cross-routing.
- MAX_OUTSTANDING=2, two grants with no responses -> s_req_o=0 and both gnt outputs 0 while requests stay high; one rvalid -> s_req_o returns to 1 next cycle.
- Push and pop in the same cycle with count=1 -> count stays 1, correct owner is routed, pointer wraps correctly over 8 back-to-back transactions.
- s_rvalid_i=1 with FIFO empty -> unexp_rsp_o=1 for one cycle, m0/m1_rvalid_o stay 0; s_err_i=1 on a valid m1 response -> m1_err_o=1.
- rst pulsed with two outstanding transactions -> all outputs 0 and count 0 during reset; a later stale rvalid -> unexp_rsp_o=1. With MEM_BUS_ARB_ROUND_ROBIN_EN, continuous contention -> grants alternate m0,m1,m0,m1.
